// File: rtl/mux_rr_sync_if.sv
// rtl/mux_rr_sync_if.sv - producer channels and consumer handshake bundle for mux_rr_sync
interface mux_rr_sync_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  localparam int SEL_W = $clog2(NCH);

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SEL_W-1:0]     out_ch;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/mux_rr_sync.sv
// rtl/mux_rr_sync.sv - registered N-channel mux with fixed-select or round-robin grant
// Optional transfer counter port xfer_cnt when MUX_RR_STATS_EN is defined.
module mux_rr_sync #(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  localparam int SEL_W = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
`ifdef MUX_RR_STATS_EN
  output logic [15:0]      xfer_cnt,
`endif
  mux_rr_sync_if.slave     bus
);

  logic [WIDTH-1:0] ch_data [NCH];
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_ch_q;
  logic             out_valid_q;
  logic [SEL_W-1:0] last_grant;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] cand;
  logic             grant_vld;
  logic             load;
  logic [NCH-1:0]   rdy;

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign ch_data[g] = bus.in_data[g*WIDTH +: WIDTH];
  end

  assign load = !out_valid_q || bus.out_ready;

  // Round-robin search starts one past the last transferred channel and wraps.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    cand      = '0;
    if (!mode) begin
      if (int'(sel) < NCH) begin
        if (bus.in_valid[sel]) begin
          grant_vld = 1'b1;
          grant     = sel;
        end
      end
    end else begin
      for (int k = 1; k <= NCH; k++) begin
        cand = SEL_W'((int'(last_grant) + k) % NCH);
        if (!grant_vld && bus.in_valid[cand]) begin
          grant_vld = 1'b1;
          grant     = cand;
        end
      end
    end
  end

  always_comb begin
    rdy = '0;
    for (int i = 0; i < NCH; i++) begin
      rdy[i] = rst_n && load && grant_vld && (grant == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      last_grant  <= SEL_W'(NCH - 1);
    end else if (load) begin
      out_valid_q <= grant_vld;
      if (grant_vld) begin
        out_data_q <= ch_data[grant];
        out_ch_q   <= grant;
        last_grant <= grant;
      end
    end
  end

`ifdef MUX_RR_STATS_EN
  logic [15:0] xfer_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready && (xfer_cnt_q != 16'hFFFF)) begin
      xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

  assign bus.in_ready  = rdy;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_sync.sv
// tb/tb_mux_rr_sync.sv - table-driven bench for mux_rr_sync (NCH=4 main, NCH=3 boundary)
module tb_mux_rr_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [1:0] sel;
  logic       rst3_n;
  logic       mode3;
  logic [1:0] sel3;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  mux_rr_sync_if #(.WIDTH(8), .NCH(4)) if4 ();
  mux_rr_sync_if #(.WIDTH(8), .NCH(3)) if3 ();

`ifdef MUX_RR_STATS_EN
  logic [15:0] cnt4;
  logic [15:0] cnt3;
`endif

  mux_rr_sync #(.WIDTH(8), .NCH(4)) u4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .sel      (sel),
`ifdef MUX_RR_STATS_EN
    .xfer_cnt (cnt4),
`endif
    .bus      (if4)
  );

  mux_rr_sync #(.WIDTH(8), .NCH(3)) u3 (
    .clk      (clk),
    .rst_n    (rst3_n),
    .mode     (mode3),
    .sel      (sel3),
`ifdef MUX_RR_STATS_EN
    .xfer_cnt (cnt3),
`endif
    .bus      (if3)
  );

  typedef struct {
    logic       rst_n;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_ir;
    logic       exp_ov;
    logic [7:0] exp_od;
    logic [1:0] exp_och;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic m, input logic [1:0] s, input logic [3:0] v,
                     input logic o, input logic [3:0] eir, input logic eov,
                     input logic [7:0] eod, input logic [1:0] eoch);
    vec_t t;
    t = '{r, m, s, v, o, eir, eov, eod, eoch};
    vq.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rows check in_ready for the row's inputs and the register state left by the previous row
    //   rst mode sel valid ordy | in_ready ov data ch
    add(0, 1, 0, 4'hF, 1, 4'b0000, 0, 8'h00, 0);
    add(0, 1, 0, 4'hF, 1, 4'b0000, 0, 8'h00, 0);
    add(1, 1, 0, 4'hF, 1, 4'b0001, 0, 8'h00, 0);
    add(1, 1, 0, 4'hF, 1, 4'b0010, 1, 8'h11, 0);
    add(1, 1, 0, 4'hF, 1, 4'b0100, 1, 8'h22, 1);
    add(1, 1, 0, 4'hF, 1, 4'b1000, 1, 8'h33, 2);
    add(1, 1, 0, 4'hF, 1, 4'b0001, 1, 8'h44, 3);
    add(1, 1, 0, 4'hF, 1, 4'b0010, 1, 8'h11, 0);
    add(1, 1, 0, 4'hA, 1, 4'b1000, 1, 8'h22, 1);
    add(1, 1, 0, 4'hA, 1, 4'b0010, 1, 8'h44, 3);
    add(1, 1, 0, 4'hA, 1, 4'b1000, 1, 8'h22, 1);
    add(1, 1, 0, 4'hA, 1, 4'b0010, 1, 8'h44, 3);
    add(1, 1, 0, 4'hA, 0, 4'b0000, 1, 8'h22, 1);
    add(1, 1, 0, 4'hA, 0, 4'b0000, 1, 8'h22, 1);
    add(1, 1, 0, 4'hA, 0, 4'b0000, 1, 8'h22, 1);
    add(1, 1, 0, 4'hA, 1, 4'b1000, 1, 8'h22, 1);
    add(1, 1, 0, 4'h0, 1, 4'b0000, 1, 8'h44, 3);
    add(1, 1, 0, 4'h0, 1, 4'b0000, 0, 8'h44, 3);
    add(1, 0, 2, 4'hF, 1, 4'b0100, 0, 8'h44, 3);
    add(1, 0, 2, 4'hF, 1, 4'b0100, 1, 8'h33, 2);
    add(1, 0, 0, 4'hF, 1, 4'b0001, 1, 8'h33, 2);
    add(1, 0, 0, 4'hF, 1, 4'b0001, 1, 8'h11, 0);
    add(1, 0, 1, 4'hF, 1, 4'b0010, 1, 8'h11, 0);
    add(1, 0, 3, 4'hF, 1, 4'b1000, 1, 8'h22, 1);
    add(1, 0, 3, 4'h7, 1, 4'b0000, 1, 8'h44, 3);
    add(1, 1, 3, 4'hF, 1, 4'b0001, 0, 8'h44, 3);
    add(1, 1, 3, 4'hF, 1, 4'b0010, 1, 8'h11, 0);
    add(0, 1, 0, 4'hF, 1, 4'b0000, 1, 8'h22, 1);
    add(0, 1, 0, 4'hF, 1, 4'b0000, 0, 8'h00, 0);
    add(1, 1, 0, 4'h4, 1, 4'b0100, 0, 8'h00, 0);
    add(1, 1, 0, 4'h0, 1, 4'b0000, 1, 8'h33, 2);

    if4.in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    if4.in_valid  = 4'hF;
    if4.out_ready = 1'b1;
    rst_n = 1'b0;
    mode  = 1'b1;
    sel   = 2'd0;
    if3.in_data   = {8'hCC, 8'hBB, 8'hAA};
    if3.in_valid  = 3'b111;
    if3.out_ready = 1'b1;
    rst3_n = 1'b0;
    mode3  = 1'b0;
    sel3   = 2'd2;
    step();

    foreach (vq[i]) begin
      rst_n         = vq[i].rst_n;
      mode          = vq[i].mode;
      sel           = vq[i].sel;
      if4.in_valid  = vq[i].valid;
      if4.out_ready = vq[i].ordy;
      @(negedge clk);
      check($sformatf("row%0d in_ready", i), 32'(if4.in_ready), 32'(vq[i].exp_ir));
      check($sformatf("row%0d out_valid", i), 32'(if4.out_valid), 32'(vq[i].exp_ov));
      check($sformatf("row%0d out_data", i), 32'(if4.out_data), 32'(vq[i].exp_od));
      check($sformatf("row%0d out_ch", i), 32'(if4.out_ch), 32'(vq[i].exp_och));
      step();
    end

    // NCH=3: out-of-range sel drains the output, then round-robin wraps from channel 2 to 0
    rst3_n = 1'b1;
    @(negedge clk);
    check("n3 ready sel2", 32'(if3.in_ready), 32'(3'b100));
    check("n3 idle valid", 32'(if3.out_valid), 32'd0);
    step();
    sel3 = 2'd3;
    @(negedge clk);
    check("n3 data ch2", 32'(if3.out_data), 32'hCC);
    check("n3 ch ch2", 32'(if3.out_ch), 32'd2);
    check("n3 ready sel3", 32'(if3.in_ready), 32'd0);
    step();
    @(negedge clk);
    check("n3 drained valid", 32'(if3.out_valid), 32'd0);
    check("n3 held data", 32'(if3.out_data), 32'hCC);
    check("n3 held ch", 32'(if3.out_ch), 32'd2);
    check("n3 ready still 0", 32'(if3.in_ready), 32'd0);
    step();
    mode3 = 1'b1;
    @(negedge clk);
    check("n3 wrap ready", 32'(if3.in_ready), 32'(3'b001));
    step();
    @(negedge clk);
    check("n3 wrap data", 32'(if3.out_data), 32'hAA);
    check("n3 wrap ch", 32'(if3.out_ch), 32'd0);
    check("n3 wrap valid", 32'(if3.out_valid), 32'd1);

`ifdef MUX_RR_STATS_EN
    step();
    rst_n = 1'b0;
    mode = 1'b1;
    if4.in_valid = 4'hF;
    if4.out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("cnt reset", 32'(cnt4), 32'd0);
    repeat (11) step();
    if4.out_ready = 1'b0;
    @(negedge clk);
    check("cnt ten", 32'(cnt4), 32'd10);
    force u4.xfer_cnt_q = 16'hFFFE;
    #1;
    release u4.xfer_cnt_q;
    step();
    if4.out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("cnt saturate", 32'(cnt4), 32'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
